ex_stage_sequencer: RTL and testbench

EX_STAGE_SEQUENCER -- requirements
Module: ex_stage_sequencer

---
 rtl/ex_stage_sequencer_pkg.sv | 25 ++
 rtl/ex_stage_sequencer_if.sv | 58 +++++
 rtl/ex_stage_sequencer_branch_cond_unit.sv | 29 ++
 rtl/ex_stage_sequencer.sv | 104 ++++++++++
 tb/tb_ex_stage_sequencer.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/ex_stage_sequencer_pkg.sv
// ex_stage_sequencer_pkg
//   Shared core definitions for the EX-stage sequencer:
//   - mc_state_t   : multi-cycle FSM state encoding (IDLE, BUSY)
//   - EX_PATH_*    : ExPathE encodings of the execution path in EX
//   - F3_*         : branch funct3 condition codes
package ex_stage_sequencer_pkg;

    typedef enum logic {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_t;

    localparam logic [1:0] EX_PATH_ALU  = 2'b00;
    localparam logic [1:0] EX_PATH_XNOR = 2'b01;
    localparam logic [1:0] EX_PATH_MC   = 2'b10;
    localparam logic [1:0] EX_PATH_RSVD = 2'b11;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/ex_stage_sequencer_if.sv
// ex_stage_sequencer_if
//   Bundles the EX-stage sequencer signals.
//   Pipeline -> sequencer : ExPathE, branch_E, jump_E, funct3_E, RegWE_E_E,
//                           ZeroE, LtE, LtuE, hz_StallF/D/E, hz_FlushD/E
//   Sequencer -> pipeline : StallF/D/E, FlushD/E, BubbleM, PCSrcE,
//                           RegWE_E_gated, mc_start, mc_done, mc_busy,
//                           mc_state_dbg (FSM state for observation)
//   master = pipeline side, slave = the sequencer.
//   Handshake: there is no valid/ready pair; every input is a level that is
//   valid every cycle, and every output is a level (or single-cycle pulse
//   for mc_start/mc_done) that applies to the instruction currently in EX.
interface ex_stage_sequencer_if;
    import ex_stage_sequencer_pkg::*;

    logic [1:0] ExPathE;
    logic       branch_E;
    logic       jump_E;
    logic [2:0] funct3_E;
    logic       RegWE_E_E;
    logic       ZeroE;
    logic       LtE;
    logic       LtuE;
    logic       hz_StallF;
    logic       hz_StallD;
    logic       hz_StallE;
    logic       hz_FlushD;
    logic       hz_FlushE;

    logic       StallF;
    logic       StallD;
    logic       StallE;
    logic       FlushD;
    logic       FlushE;
    logic       BubbleM;
    logic       PCSrcE;
    logic       RegWE_E_gated;
    logic       mc_start;
    logic       mc_done;
    logic       mc_busy;
    mc_state_t  mc_state_dbg;

    modport master (
        output ExPathE, branch_E, jump_E, funct3_E, RegWE_E_E,
               ZeroE, LtE, LtuE,
               hz_StallF, hz_StallD, hz_StallE, hz_FlushD, hz_FlushE,
        input  StallF, StallD, StallE, FlushD, FlushE, BubbleM, PCSrcE,
               RegWE_E_gated, mc_start, mc_done, mc_busy, mc_state_dbg
    );

    modport slave (
        input  ExPathE, branch_E, jump_E, funct3_E, RegWE_E_E,
               ZeroE, LtE, LtuE,
               hz_StallF, hz_StallD, hz_StallE, hz_FlushD, hz_FlushE,
        output StallF, StallD, StallE, FlushD, FlushE, BubbleM, PCSrcE,
               RegWE_E_gated, mc_start, mc_done, mc_busy, mc_state_dbg
    );

endinterface

// File: rtl/ex_stage_sequencer_branch_cond_unit.sv
// branch_cond_unit
//   Purely combinational branch-condition evaluation from the ALU flags.
//   Ports: funct3 (condition select), zero/lt/ltu (ALU flags: equal,
//   signed less-than, unsigned less-than), cond (condition true).
//   funct3 codes 010/011 are not branches and evaluate false.
module branch_cond_unit
    import ex_stage_sequencer_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    output logic       cond
);

    always_comb begin
        cond = 1'b0;
        case (funct3)
            F3_BEQ:  cond = zero;
            F3_BNE:  cond = ~zero;
            F3_BLT:  cond = lt;
            F3_BGE:  cond = ~lt;
            F3_BLTU: cond = ltu;
            F3_BGEU: cond = ~ltu;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_stage_sequencer.sv
// ex_stage_sequencer
//   Merges hazard-unit requests with branch redirection and multi-cycle
//   EX sequencing into the final pipeline controls.
//   Parameter: MC_LATENCY (2..16) total EX occupancy of a multi-cycle op.
//   Ports: clk, reset (async, active-high), bus (ex_stage_sequencer_if.slave).
//   A multi-cycle op occupies EX for MC_LATENCY cycles: stalls are raised in
//   the first MC_LATENCY-1 and mc_done/RegWE_E_gated in the last, so the
//   instruction leaves EX on the same edge its result is written.
module ex_stage_sequencer
    import ex_stage_sequencer_pkg::*;
#(
    parameter int MC_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    ex_stage_sequencer_if.slave   bus
);

    // Trigger cycle is the first of MC_LATENCY, so BUSY counts the rest
    // down to zero: MC_LATENCY-2 remaining stall cycles after the trigger.
    localparam logic [3:0] CNT_LOAD = 4'(MC_LATENCY - 2);

    mc_state_t  state;
    logic [3:0] cnt;
    logic       mc_busy_q;
    logic       mc_done_q;

    logic       br_cond;
    logic       pc_src;
    logic       trigger;
    logic       mc_stall;

    branch_cond_unit u_branch_cond (
        .funct3 (bus.funct3_E),
        .zero   (bus.ZeroE),
        .lt     (bus.LtE),
        .ltu    (bus.LtuE),
        .cond   (br_cond)
    );

    assign pc_src = bus.jump_E | (bus.branch_E & br_cond);

    // Reset gates the trigger so that no stall is seen while reset is held,
    // even with a multi-cycle op sitting in EX.
    assign trigger  = ~reset & (state == MC_IDLE) & (bus.ExPathE == EX_PATH_MC);
    assign mc_stall = trigger | ((state == MC_BUSY) & (cnt != 4'd0));

    // mc_busy mirrors state==BUSY and mc_done mirrors state==BUSY && cnt==0;
    // both are produced as flops alongside the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= MC_IDLE;
            cnt       <= 4'd0;
            mc_busy_q <= 1'b0;
            mc_done_q <= 1'b0;
        end else begin
            case (state)
                MC_IDLE: begin
                    if (bus.ExPathE == EX_PATH_MC) begin
                        state     <= MC_BUSY;
                        cnt       <= CNT_LOAD;
                        mc_busy_q <= 1'b1;
                        mc_done_q <= (CNT_LOAD == 4'd0);
                    end else begin
                        mc_busy_q <= 1'b0;
                        mc_done_q <= 1'b0;
                    end
                end
                MC_BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt       <= cnt - 4'd1;
                        mc_busy_q <= 1'b1;
                        mc_done_q <= (cnt == 4'd1);
                    end else begin
                        state     <= MC_IDLE;
                        mc_busy_q <= 1'b0;
                        mc_done_q <= 1'b0;
                    end
                end
                default: begin
                    state     <= MC_IDLE;
                    cnt       <= 4'd0;
                    mc_busy_q <= 1'b0;
                    mc_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.PCSrcE        = pc_src;
    assign bus.StallF        = bus.hz_StallF | mc_stall;
    assign bus.StallD        = bus.hz_StallD | mc_stall;
    assign bus.StallE        = bus.hz_StallE | mc_stall;
    assign bus.BubbleM       = mc_stall;
    assign bus.FlushD        = bus.hz_FlushD | pc_src;
    // The hazard unit must not kill a multi-cycle op still occupying EX.
    assign bus.FlushE        = (bus.hz_FlushE & ~mc_stall) | pc_src;
    assign bus.RegWE_E_gated = bus.RegWE_E_E & ~mc_stall;
    assign bus.mc_start      = trigger;
    assign bus.mc_done       = mc_done_q;
    assign bus.mc_busy       = mc_busy_q;
    assign bus.mc_state_dbg  = state;

endmodule

// File: tb/tb_ex_stage_sequencer.sv
// tb_ex_stage_sequencer
//   Directed-vector bench for ex_stage_sequencer (MC_LATENCY = 4).
//   Driver applies one input vector per cycle (#1 after posedge) and pushes
//   the hand-computed output vector; a monitor pops and compares at negedge.
module tb_ex_stage_sequencer;
    import ex_stage_sequencer_pkg::*;

    localparam int W = 11;

    // Input vector fields.
    typedef struct packed {
        logic [1:0] path;
        logic       br;
        logic       jp;
        logic [2:0] f3;
        logic       we;
        logic       z;
        logic       lt;
        logic       ltu;
        logic [4:0] hz;   // {hz_StallF, hz_StallD, hz_StallE, hz_FlushD, hz_FlushE}
        logic       rst;
    } vin_t;

    logic clk;
    logic reset;

    ex_stage_sequencer_if bus ();

    ex_stage_sequencer #(.MC_LATENCY(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           check_cnt = 0;
    int           pass_cnt  = 0;

    // Expected/actual layout: {StallF,StallD,StallE, FlushD,FlushE, BubbleM,
    //                          PCSrcE, RegWE_E_gated, mc_start, mc_done, mc_busy}
    logic [W-1:0] mon_act;
    logic [W-1:0] mon_exp;
    string        mon_name;

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            mon_act  = {bus.StallF, bus.StallD, bus.StallE, bus.FlushD, bus.FlushE,
                        bus.BubbleM, bus.PCSrcE, bus.RegWE_E_gated,
                        bus.mc_start, bus.mc_done, bus.mc_busy};
            check_cnt++;
            if (mon_act === mon_exp) pass_cnt++;
            else $display("FAIL %s: got %b required %b", mon_name, mon_act, mon_exp);
        end
    end

    // ---------------- driver ----------------
    function automatic vin_t mk_in(input logic [1:0] path, input logic br, input logic jp,
                                   input logic [2:0] f3, input logic we, input logic z,
                                   input logic lt, input logic ltu, input logic [4:0] hz,
                                   input logic rst);
        vin_t v;
        v.path = path; v.br = br; v.jp = jp; v.f3 = f3; v.we = we;
        v.z = z; v.lt = lt; v.ltu = ltu; v.hz = hz; v.rst = rst;
        return v;
    endfunction

    task automatic apply(input vin_t v);
        bus.ExPathE   = v.path;
        bus.branch_E  = v.br;
        bus.jump_E    = v.jp;
        bus.funct3_E  = v.f3;
        bus.RegWE_E_E = v.we;
        bus.ZeroE     = v.z;
        bus.LtE       = v.lt;
        bus.LtuE      = v.ltu;
        bus.hz_StallF = v.hz[4];
        bus.hz_StallD = v.hz[3];
        bus.hz_StallE = v.hz[2];
        bus.hz_FlushD = v.hz[1];
        bus.hz_FlushE = v.hz[0];
        reset         = v.rst;
    endtask

    task automatic step(input vin_t v, input logic [W-1:0] e, input string nm);
        @(posedge clk);
        #1;
        apply(v);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Multi-cycle op held in EX with RegWE set, optional hazard FlushE.
    function automatic vin_t mc_in(input logic hfe, input logic rst);
        return mk_in(EX_PATH_MC, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0,
                     {4'b0000, hfe}, rst);
    endfunction

    function automatic vin_t idle_in();
        return mk_in(EX_PATH_ALU, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 5'b0, 1'b0);
    endfunction

    //                  stall  flush bm pc wg st dn bz
    localparam logic [W-1:0] O_ZERO  = 11'b000_00_0_0_0_0_0_0;
    localparam logic [W-1:0] O_WE    = 11'b000_00_0_0_1_0_0_0;
    localparam logic [W-1:0] O_BR    = 11'b000_11_0_1_0_0_0_0;
    localparam logic [W-1:0] O_MC0   = 11'b111_00_1_0_0_1_0_0;
    localparam logic [W-1:0] O_MCB   = 11'b111_00_1_0_0_0_0_1;
    localparam logic [W-1:0] O_MCD   = 11'b000_00_0_0_1_0_1_1;
    localparam logic [W-1:0] O_MC0B  = 11'b111_00_1_0_0_1_0_0;

    initial begin
        apply(mk_in(EX_PATH_MC, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 5'b0, 1'b1));

        // Reset state, including a multi-cycle op present during reset.
        step(mk_in(EX_PATH_ALU, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 5'b0, 1'b1), O_ZERO, "reset_idle");
        step(mk_in(EX_PATH_MC,  1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 5'b0, 1'b1), O_ZERO, "reset_mc_no_stall");

        // Plain ALU and branch conditions.
        step(mk_in(EX_PATH_ALU, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 5'b0, 1'b0), O_WE,   "alu_we");
        step(mk_in(EX_PATH_ALU, 1'b1, 1'b0, F3_BEQ,  1'b0, 1'b1, 1'b0, 1'b0, 5'b0, 1'b0), O_BR,   "beq_taken");
        step(mk_in(EX_PATH_ALU, 1'b1, 1'b0, F3_BEQ,  1'b0, 1'b0, 1'b0, 1'b0, 5'b0, 1'b0), O_ZERO, "beq_not_taken");
        step(mk_in(EX_PATH_ALU, 1'b1, 1'b0, F3_BNE,  1'b0, 1'b0, 1'b0, 1'b0, 5'b0, 1'b0), O_BR,   "bne_taken");
        step(mk_in(EX_PATH_ALU, 1'b1, 1'b0, F3_BLT,  1'b0, 1'b0, 1'b1, 1'b0, 5'b0, 1'b0), O_BR,   "blt_taken");
        step(mk_in(EX_PATH_ALU, 1'b1, 1'b0, F3_BGE,  1'b0, 1'b0, 1'b1, 1'b0, 5'b0, 1'b0), O_ZERO, "bge_not_taken");
        step(mk_in(EX_PATH_ALU, 1'b1, 1'b0, F3_BLTU, 1'b0, 1'b0, 1'b0, 1'b1, 5'b0, 1'b0), O_BR,   "bltu_taken");
        step(mk_in(EX_PATH_ALU, 1'b1, 1'b0, F3_BGEU, 1'b0, 1'b0, 1'b0, 1'b0, 5'b0, 1'b0), O_BR,   "bgeu_taken");
        step(mk_in(EX_PATH_ALU, 1'b1, 1'b0, 3'b010,  1'b0, 1'b1, 1'b1, 1'b1, 5'b0, 1'b0), O_ZERO, "f3_010_never");
        step(mk_in(EX_PATH_ALU, 1'b1, 1'b0, 3'b011,  1'b0, 1'b1, 1'b1, 1'b1, 5'b0, 1'b0), O_ZERO, "f3_011_never");
        step(mk_in(EX_PATH_ALU, 1'b0, 1'b1, 3'b010,  1'b0, 1'b0, 1'b1, 1'b0, 5'b0, 1'b0), O_BR,   "jump_any_flags");

        // Hazard pass-through and non-stalling paths.
        step(mk_in(EX_PATH_ALU,  1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11111, 1'b0),
             11'b111_11_0_0_0_0_0_0, "hazard_passthrough");
        step(mk_in(EX_PATH_XNOR, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 5'b0, 1'b0), O_WE, "xnor_no_stall");
        step(mk_in(EX_PATH_RSVD, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 5'b0, 1'b0), O_WE, "rsvd_no_stall");

        // Single multi-cycle op, latency 4.
        step(mc_in(1'b0, 1'b0), O_MC0, "mc1_c0");
        step(mc_in(1'b0, 1'b0), O_MCB, "mc1_c1");
        step(mc_in(1'b0, 1'b0), O_MCB, "mc1_c2");
        step(mc_in(1'b0, 1'b0), O_MCD, "mc1_c3_done");
        step(idle_in(), O_ZERO, "mc1_after");

        // Back-to-back multi-cycle ops.
        step(mc_in(1'b0, 1'b0), O_MC0,  "b2b_a_c0");
        step(mc_in(1'b0, 1'b0), O_MCB,  "b2b_a_c1");
        step(mc_in(1'b0, 1'b0), O_MCB,  "b2b_a_c2");
        step(mc_in(1'b0, 1'b0), O_MCD,  "b2b_a_c3_done");
        step(mc_in(1'b0, 1'b0), O_MC0B, "b2b_b_c0");
        step(mc_in(1'b0, 1'b0), O_MCB,  "b2b_b_c1");
        step(mc_in(1'b0, 1'b0), O_MCB,  "b2b_b_c2");
        step(mc_in(1'b0, 1'b0), O_MCD,  "b2b_b_c3_done");
        step(idle_in(), O_ZERO, "b2b_after");

        // Hazard FlushE during a multi-cycle op is suppressed.
        step(mc_in(1'b0, 1'b0), O_MC0, "hfe_c0");
        step(mc_in(1'b1, 1'b0), O_MCB, "hfe_c1_suppressed");
        step(mc_in(1'b0, 1'b0), O_MCB, "hfe_c2");
        step(mc_in(1'b0, 1'b0), O_MCD, "hfe_c3_done");
        step(idle_in(), O_ZERO, "hfe_after");

        // Reset mid-sequence, then a fresh full-length restart.
        step(mc_in(1'b0, 1'b0), O_MC0, "rst_c0");
        step(mc_in(1'b0, 1'b0), O_MCB, "rst_c1");
        step(mc_in(1'b0, 1'b1), O_WE,  "rst_c2_reset");
        step(mc_in(1'b0, 1'b0), O_MC0, "restart_c0");
        step(mc_in(1'b0, 1'b0), O_MCB, "restart_c1");
        step(mc_in(1'b0, 1'b0), O_MCB, "restart_c2");
        step(mc_in(1'b0, 1'b0), O_MCD, "restart_c3_done");
        step(idle_in(), O_ZERO, "restart_after");

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            check_cnt++;
            $display("FAIL drain: got %0d pending, required 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
